// File: rtl/mips_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multi-cycle MIPS control unit: FSM state
// encoding, opcode and funct field values, ALU_CONTROL codes and the
// ALUOp encoding passed from the FSM to the ALU decoder.
// No ports (package).
// ---------------------------------------------------------------------------
package mips_ctrl_pkg;

  // FSM states, binary encoded in STATE_W bits
  localparam int STATE_W = 4;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_FETCH  = 4'd0;
  localparam state_t S_DECODE = 4'd1;
  localparam state_t S_MEMADR = 4'd2;
  localparam state_t S_MEMRD  = 4'd3;
  localparam state_t S_MEMWR  = 4'd4;
  localparam state_t S_MEMWB  = 4'd5;
  localparam state_t S_EXEC   = 4'd6;
  localparam state_t S_ALUWB  = 4'd7;
  localparam state_t S_BRANCH = 4'd8;
  localparam state_t S_ADDIEX = 4'd9;
  localparam state_t S_ADDIWB = 4'd10;
  localparam state_t S_JUMP   = 4'd11;

  // Instruction opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct values
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU_CONTROL codes (3 bits, zero-extended at the top level)
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Operation requested by the FSM; FUNCT defers the choice to the funct field
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  // States that wait on the memory handshake and therefore run the timeout counter
  function automatic logic isWaitState(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// ---------------------------------------------------------------------------
// mc_alu_decoder
// Combinational ALU decoder carried over from the single-cycle control unit.
// Maps the FSM's ALUOp request plus the R-type funct field onto a 3-bit
// ALU_CONTROL code.
// Ports:
//   i_aluOp   - ALUOp from the FSM (add, sub or use funct)
//   i_funct   - R-type funct field
//   o_aluCtrl - ALU operation code
// ---------------------------------------------------------------------------
module mc_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  aluop_e     i_aluOp,
  input  logic [5:0] i_funct,
  output logic [2:0] o_aluCtrl
);

  // Unknown funct values (and the unused ALUOp encoding) fall back to add so
  // the datapath always sees a defined operation.
  always_comb begin
    o_aluCtrl = ALU_ADD;
    case (i_aluOp)
      ALUOP_ADD: o_aluCtrl = ALU_ADD;
      ALUOP_SUB: o_aluCtrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          FN_ADD:  o_aluCtrl = ALU_ADD;
          FN_SUB:  o_aluCtrl = ALU_SUB;
          FN_AND:  o_aluCtrl = ALU_AND;
          FN_OR:   o_aluCtrl = ALU_OR;
          FN_SLT:  o_aluCtrl = ALU_SLT;
          default: o_aluCtrl = ALU_ADD;
        endcase
      end
      default: o_aluCtrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit
// Moore-style control FSM for the shared-datapath multi-cycle MIPS core.
// Each instruction walks FETCH -> DECODE -> (execute/memory/writeback) and
// returns to FETCH. Memory states wait on mem_ready; a wait counter aborts a
// stalled access after TIMEOUT cycles with a one-cycle mem_err pulse.
//
// Optional build macro: BNE_EN
//   defined   - opcode 000101 (bne) shares the BRANCH state; the branch is
//               taken on ~zero for bne and zero for beq.
//   undefined - 000101 is reported as illegal.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   opcode, FUNCT   - instruction fields from the instruction register
//   zero            - ALU zero flag
//   mem_ready       - memory access completes this cycle
//   IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
//   ALUSrcA, ALUSrcB, ALU_CONTROL, PCSrc, PCEn
//                   - datapath mux selects and enables
//   mem_err         - one-cycle pulse on memory timeout
//   illegal         - one-cycle pulse on an unknown opcode in DECODE
// ---------------------------------------------------------------------------
module multicycle_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 3,
  parameter int WAIT_W     = 4,
  parameter int TIMEOUT    = 15   // must be < 2**WAIT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            opcode,
  input  logic [5:0]            FUNCT,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  IorD,
  output logic                  MemWrite,
  output logic                  IRWrite,
  output logic                  RegDst,
  output logic                  MemtoReg,
  output logic                  RegWrite,
  output logic                  ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [ALU_CTRL_W-1:0] ALU_CONTROL,
  output logic [1:0]            PCSrc,
  output logic                  PCEn,
  output logic                  mem_err,
  output logic                  illegal
);

  state_t            r_state;
  state_t            w_nextState;
  logic [WAIT_W-1:0] r_waitCnt;
  logic              w_waitState;
  logic              w_timeout;
  logic              w_knownOp;
  logic              w_branchTaken;
  aluop_e            w_aluOp;
  logic [2:0]        w_aluCtrl;

  assign w_waitState = isWaitState(r_state);

  // mem_ready in the timeout cycle wins, so the timeout needs it low
  assign w_timeout = w_waitState && !mem_ready &&
                     (r_waitCnt == WAIT_W'(TIMEOUT));

`ifdef BNE_EN
  logic r_isBne;

  // DECODE is the last point where the opcode is guaranteed to belong to
  // this branch, so remember whether it was bne for the BRANCH state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_isBne <= 1'b0;
    end else if (r_state == S_DECODE) begin
      r_isBne <= (opcode == OP_BNE);
    end
  end

  assign w_branchTaken = r_isBne ? ~zero : zero;
`else
  assign w_branchTaken = zero;
`endif

  // Opcodes DECODE knows how to dispatch; anything else raises illegal.
  always_comb begin
    w_knownOp = 1'b0;
    case (opcode)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: w_knownOp = 1'b1;
`ifdef BNE_EN
      OP_BNE: w_knownOp = 1'b1;
`endif
      default: w_knownOp = 1'b0;
    endcase
  end

  // Next-state logic. Wait states hold until mem_ready and bail out to
  // FETCH on timeout; every terminal state returns to FETCH.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_FETCH: begin
        if (mem_ready) begin
          w_nextState = S_DECODE;
        end else if (w_timeout) begin
          w_nextState = S_FETCH;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_nextState = S_MEMADR;
          OP_RTYPE:     w_nextState = S_EXEC;
          OP_BEQ:       w_nextState = S_BRANCH;
`ifdef BNE_EN
          OP_BNE:       w_nextState = S_BRANCH;
`endif
          OP_ADDI:      w_nextState = S_ADDIEX;
          OP_J:         w_nextState = S_JUMP;
          default:      w_nextState = S_FETCH;
        endcase
      end
      S_MEMADR: w_nextState = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (mem_ready) begin
          w_nextState = S_MEMWB;
        end else if (w_timeout) begin
          w_nextState = S_FETCH;
        end
      end
      S_MEMWR: begin
        if (mem_ready || w_timeout) begin
          w_nextState = S_FETCH;
        end
      end
      S_EXEC:   w_nextState = S_ALUWB;
      S_ADDIEX: w_nextState = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: w_nextState = S_FETCH;
      default:  w_nextState = S_FETCH;
    endcase
  end

  // State register and wait counter. The counter only survives while the
  // FSM sits in the same wait state without mem_ready; any transition,
  // completion or timeout clears it, which gives the clear-on-entry behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_waitCnt <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_waitState && !mem_ready && !w_timeout) begin
        r_waitCnt <= r_waitCnt + WAIT_W'(1);
      end else begin
        r_waitCnt <= '0;
      end
    end
  end

  // Output decode. Everything defaults to 0 / add so unlisted strobes stay
  // low; the timeout cycle suppresses all strobes while keeping the selects.
  always_comb begin
    IorD     = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    w_aluOp  = ALUOP_ADD;
    PCSrc    = 2'b00;
    PCEn     = 1'b0;
    mem_err  = w_timeout;
    illegal  = 1'b0;
    case (r_state)
      S_FETCH: begin
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCEn    = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        illegal = !w_knownOp;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: IorD = 1'b1;
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = !w_timeout;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        w_aluOp = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        w_aluOp = ALUOP_SUB;
        PCSrc   = 2'b01;
        PCEn    = w_branchTaken;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_JUMP: begin
        PCSrc = 2'b10;
        PCEn  = 1'b1;
      end
      default: ;
    endcase
  end

  mc_alu_decoder u_aluDecoder (
    .i_aluOp   (w_aluOp),
    .i_funct   (FUNCT),
    .o_aluCtrl (w_aluCtrl)
  );

  assign ALU_CONTROL = ALU_CTRL_W'(w_aluCtrl);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_unit
// Directed scoreboard bench for multicycle_control_unit. Each stimulus cycle
// pushes a hand-written expected output vector (with a care mask for selects
// that are don't-care in that state); a monitor pops one entry per cycle and
// compares it against the DUT outputs on the falling edge.
// ---------------------------------------------------------------------------
module tb_multicycle_control_unit;

  localparam logic [5:0] T_RTYPE = 6'b000000;
  localparam logic [5:0] T_J     = 6'b000010;
  localparam logic [5:0] T_BEQ   = 6'b000100;
  localparam logic [5:0] T_BNE   = 6'b000101;
  localparam logic [5:0] T_ADDI  = 6'b001000;
  localparam logic [5:0] T_LW    = 6'b100011;
  localparam logic [5:0] T_SW    = 6'b101011;
  localparam logic [5:0] T_BAD   = 6'b111111;

  typedef struct packed {
    logic       iorD;
    logic       memWrite;
    logic       irWrite;
    logic       regDst;
    logic       memtoReg;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluCtrl;
    logic [1:0] pcSrc;
    logic       pcEn;
    logic       memErr;
    logic       illegal;
  } outVec_t;

  typedef struct {
    outVec_t val;
    outVec_t care;
    string   name;
  } entry_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] FUNCT = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALU_CONTROL;
  logic       PCEn, mem_err, illegal;

  outVec_t act;
  entry_t  expQ[$];
  int      checks = 0;
  int      errors = 0;

  multicycle_control_unit #(
    .ALU_CTRL_W (3),
    .WAIT_W     (4),
    .TIMEOUT    (15)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .FUNCT       (FUNCT),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .IorD        (IorD),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .RegDst      (RegDst),
    .MemtoReg    (MemtoReg),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALU_CONTROL (ALU_CONTROL),
    .PCSrc       (PCSrc),
    .PCEn        (PCEn),
    .mem_err     (mem_err),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  assign act = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                ALUSrcB, ALU_CONTROL, PCSrc, PCEn, mem_err, illegal};

  // Expected-vector builders: strobes are always checked, selects only
  // where the state defines them.
  function automatic entry_t base(input string n);
    entry_t e;
    e.name = n;
    e.val  = '0;
    e.care = '0;
    e.care.memWrite = 1'b1;
    e.care.irWrite  = 1'b1;
    e.care.regWrite = 1'b1;
    e.care.pcEn     = 1'b1;
    e.care.memErr   = 1'b1;
    e.care.illegal  = 1'b1;
    return e;
  endfunction

  function automatic entry_t withAlu(input entry_t ein, input logic a,
                                     input logic [1:0] b, input logic [2:0] c);
    entry_t e = ein;
    e.val.aluSrcA  = a;  e.care.aluSrcA = 1'b1;
    e.val.aluSrcB  = b;  e.care.aluSrcB = 2'b11;
    e.val.aluCtrl  = c;  e.care.aluCtrl = 3'b111;
    return e;
  endfunction

  function automatic entry_t expFetch(input logic mr, input logic err);
    entry_t e = withAlu(base(err ? "fetchTimeout" : "fetch"), 1'b0, 2'b01, 3'b010);
    e.val.iorD  = 1'b0; e.care.iorD  = 1'b1;
    e.val.pcSrc = 2'b00; e.care.pcSrc = 2'b11;
    e.val.irWrite = mr;
    e.val.pcEn    = mr;
    e.val.memErr  = err;
    return e;
  endfunction

  function automatic entry_t expDecode(input logic ill);
    entry_t e = withAlu(base(ill ? "decodeIllegal" : "decode"), 1'b0, 2'b11, 3'b010);
    e.val.illegal = ill;
    return e;
  endfunction

  function automatic entry_t expMemAdr();
    return withAlu(base("memAdr"), 1'b1, 2'b10, 3'b010);
  endfunction

  function automatic entry_t expMemRd(input logic err);
    entry_t e = base(err ? "memRdTimeout" : "memRd");
    e.val.iorD = 1'b1; e.care.iorD = 1'b1;
    e.val.memErr = err;
    return e;
  endfunction

  function automatic entry_t expMemWr(input logic err);
    entry_t e = base(err ? "memWrTimeout" : "memWr");
    e.val.iorD = 1'b1; e.care.iorD = 1'b1;
    e.val.memWrite = !err;
    e.val.memErr   = err;
    return e;
  endfunction

  function automatic entry_t expWb(input string n, input logic rd, input logic m2r);
    entry_t e = base(n);
    e.val.regDst   = rd;  e.care.regDst   = 1'b1;
    e.val.memtoReg = m2r; e.care.memtoReg = 1'b1;
    e.val.regWrite = 1'b1;
    return e;
  endfunction

  function automatic entry_t expBranch(input logic taken);
    entry_t e = withAlu(base("branch"), 1'b1, 2'b00, 3'b110);
    e.val.pcSrc = 2'b01; e.care.pcSrc = 2'b11;
    e.val.pcEn  = taken;
    return e;
  endfunction

  function automatic entry_t expJump();
    entry_t e = base("jump");
    e.val.pcSrc = 2'b10; e.care.pcSrc = 2'b11;
    e.val.pcEn  = 1'b1;
    return e;
  endfunction

  // Drive one cycle of inputs and queue the outputs expected in that cycle
  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                               input logic z, input logic mr, input logic r,
                               input entry_t e);
    opcode    = op;
    FUNCT     = fn;
    zero      = z;
    mem_ready = mr;
    rst       = r;
    expQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic fetchDecode(input logic [5:0] op);
    applyStimulus(op, 6'b0, 1'b0, 1'b1, 1'b0, expFetch(1'b1, 1'b0));
    applyStimulus(op, 6'b0, 1'b0, 1'b1, 1'b0, expDecode(1'b0));
  endtask

  task automatic checkOutput(input entry_t e);
    logic [17:0] a, v, c;
    a = act;
    v = e.val;
    c = e.care;
    checks++;
    if ((a & c) !== (v & c)) begin
      errors++;
      $display("[TB] FAIL %s: got %b required %b (care %b)", e.name, a & c, v & c, c);
    end
  endtask

  // Monitor: one queued expectation per cycle, checked mid-cycle
  initial begin
    entry_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    logic [5:0] fnTab [6];
    logic [2:0] ctlTab [6];
    fnTab  = '{6'b101010, 6'b100010, 6'b100000, 6'b100100, 6'b100101, 6'b000111};
    ctlTab = '{3'b111,    3'b110,    3'b010,    3'b000,    3'b001,    3'b010};

    repeat (2) @(posedge clk);
    #1;

    // reset state, then lw with memory always ready (5 states)
    applyStimulus(T_LW, 6'b0, 1'b0, 1'b0, 1'b0, expFetch(1'b0, 1'b0));
    fetchDecode(T_LW);
    applyStimulus(T_LW, 6'b0, 1'b0, 1'b1, 1'b0, expMemAdr());
    applyStimulus(T_LW, 6'b0, 1'b0, 1'b1, 1'b0, expMemRd(1'b0));
    applyStimulus(T_LW, 6'b0, 1'b0, 1'b1, 1'b0, expWb("memWb", 1'b0, 1'b1));

    // R-type with a range of funct values
    for (int i = 0; i < 6; i++) begin
      fetchDecode(T_RTYPE);
      applyStimulus(T_RTYPE, fnTab[i], 1'b0, 1'b1, 1'b0,
                    withAlu(base("exec"), 1'b1, 2'b00, ctlTab[i]));
      applyStimulus(T_RTYPE, fnTab[i], 1'b0, 1'b1, 1'b0, expWb("aluWb", 1'b1, 1'b0));
    end

    // addi
    fetchDecode(T_ADDI);
    applyStimulus(T_ADDI, 6'b0, 1'b0, 1'b1, 1'b0,
                  withAlu(base("addiEx"), 1'b1, 2'b10, 3'b010));
    applyStimulus(T_ADDI, 6'b0, 1'b0, 1'b1, 1'b0, expWb("addiWb", 1'b0, 1'b0));

    // beq taken and not taken
    fetchDecode(T_BEQ);
    applyStimulus(T_BEQ, 6'b0, 1'b1, 1'b1, 1'b0, expBranch(1'b1));
    fetchDecode(T_BEQ);
    applyStimulus(T_BEQ, 6'b0, 1'b0, 1'b1, 1'b0, expBranch(1'b0));

    // jump
    fetchDecode(T_J);
    applyStimulus(T_J, 6'b0, 1'b0, 1'b1, 1'b0, expJump());

    // unknown opcode returns straight to FETCH
    applyStimulus(T_BAD, 6'b0, 1'b0, 1'b1, 1'b0, expFetch(1'b1, 1'b0));
    applyStimulus(T_BAD, 6'b0, 1'b0, 1'b1, 1'b0, expDecode(1'b1));
    applyStimulus(T_BAD, 6'b0, 1'b0, 1'b0, 1'b0, expFetch(1'b0, 1'b0));

    // bne
`ifdef BNE_EN
    fetchDecode(T_BNE);
    applyStimulus(T_BNE, 6'b0, 1'b0, 1'b1, 1'b0, expBranch(1'b1));
    fetchDecode(T_BNE);
    applyStimulus(T_BNE, 6'b0, 1'b1, 1'b1, 1'b0, expBranch(1'b0));
`else
    applyStimulus(T_BNE, 6'b0, 1'b0, 1'b1, 1'b0, expFetch(1'b1, 1'b0));
    applyStimulus(T_BNE, 6'b0, 1'b0, 1'b1, 1'b0, expDecode(1'b1));
    applyStimulus(T_BNE, 6'b0, 1'b0, 1'b0, 1'b0, expFetch(1'b0, 1'b0));
`endif

    // sw with two wait cycles in MEMWR
    fetchDecode(T_SW);
    applyStimulus(T_SW, 6'b0, 1'b0, 1'b1, 1'b0, expMemAdr());
    applyStimulus(T_SW, 6'b0, 1'b0, 1'b0, 1'b0, expMemWr(1'b0));
    applyStimulus(T_SW, 6'b0, 1'b0, 1'b0, 1'b0, expMemWr(1'b0));
    applyStimulus(T_SW, 6'b0, 1'b0, 1'b1, 1'b0, expMemWr(1'b0));

    // lw stalled in MEMRD until timeout
    fetchDecode(T_LW);
    applyStimulus(T_LW, 6'b0, 1'b0, 1'b1, 1'b0, expMemAdr());
    for (int i = 0; i < 15; i++)
      applyStimulus(T_LW, 6'b0, 1'b0, 1'b0, 1'b0, expMemRd(1'b0));
    applyStimulus(T_LW, 6'b0, 1'b0, 1'b0, 1'b0, expMemRd(1'b1));

    // reset during a MEMWR wait, then a full FETCH timeout from a clean counter
    fetchDecode(T_SW);
    applyStimulus(T_SW, 6'b0, 1'b0, 1'b1, 1'b0, expMemAdr());
    for (int i = 0; i < 5; i++)
      applyStimulus(T_SW, 6'b0, 1'b0, 1'b0, 1'b0, expMemWr(1'b0));
    applyStimulus(T_SW, 6'b0, 1'b0, 1'b0, 1'b1, expMemWr(1'b0));
    for (int i = 0; i < 15; i++)
      applyStimulus(T_SW, 6'b0, 1'b0, 1'b0, 1'b0, expFetch(1'b0, 1'b0));
    applyStimulus(T_SW, 6'b0, 1'b0, 1'b0, 1'b0, expFetch(1'b0, 1'b1));
    applyStimulus(T_SW, 6'b0, 1'b0, 1'b1, 1'b0, expFetch(1'b1, 1'b0));

    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
    if (expQ.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
    end
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
